// File: rtl/fetch_ctrl.sv
//==============================================================================
// fetch_ctrl : instruction-fetch controller (PC stepping, imem read, holding).
// Optional macro FETCH_ALIGN_CHECK_EN enables misaligned-redirect detection.
// Revision: 1.0
//==============================================================================
`default_nettype none

module fetch_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] curr_pc_i,
    output logic [31:0] next_pc_o,
    output logic        pc_en_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fetch_err_o,
    output logic        misalign_err_o
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] C_TIMEOUT = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            err_q, err_d;
    logic [31:0]     redir_target;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign redir_target = {redirect_pc_i[31:2], 2'b00};
    assign misalign_d   = misalign_q |
                          (redirect_i && (state_q != S_IDLE) && (|redirect_pc_i[1:0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_err_o = misalign_q;
`else
    assign redir_target   = redirect_pc_i;
    assign misalign_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        next_pc_o     = '0;
        pc_en_o       = 1'b0;
        imem_req_o    = 1'b0;
        imem_addr_o   = '0;
        instr_valid_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req_o  = 1'b1;
                imem_addr_o = curr_pc_i;
                if (redirect_i) begin
                    pc_en_o   = 1'b1;
                    next_pc_o = redir_target;
                    // A response still in flight must be drained before refetching.
                    state_d   = imem_rvalid_i ? S_FETCH : S_DRAIN;
                end else if (imem_rvalid_i) begin
                    instr_d = imem_rdata_i;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                instr_valid_o = 1'b1;
                if (redirect_i) begin
                    pc_en_o   = 1'b1;
                    next_pc_o = redir_target;
                    state_d   = S_FETCH;
                end else if (instr_ready_i) begin
                    pc_en_o   = 1'b1;
                    next_pc_o = curr_pc_i + 32'd4;
                    state_d   = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (redirect_i) begin
                    pc_en_o   = 1'b1;
                    next_pc_o = redir_target;
                end
                if (imem_rvalid_i) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Watchdog: timer only runs while a FETCH request is outstanding.
    always_comb begin
        timer_d = timer_q;
        err_d   = err_q;
        if ((state_q != S_FETCH) || imem_rvalid_i) begin
            timer_d = '0;
        end else if (timer_q != C_TIMEOUT) begin
            timer_d = timer_q + TW'(1);
        end
        if ((TIMEOUT != 0) && (state_q == S_FETCH) && !imem_rvalid_i &&
            (timer_d == C_TIMEOUT)) begin
            err_d = 1'b1;
        end
    end

    assign instr_o     = instr_q;
    assign fetch_err_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
//==============================================================================
// tb_fetch_ctrl : directed vector bench for fetch_ctrl (TIMEOUT = 4).
// Honours FETCH_ALIGN_CHECK_EN when computing expected redirect targets.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_fetch_ctrl;

    localparam logic O = 1'b0;
    localparam logic I = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic ALN = 1'b1;
`else
    localparam logic ALN = 1'b0;
`endif
    localparam logic [31:0] NP = ALN ? 32'h0000_0100 : 32'h0000_0102;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] curr_pc;
    logic [31:0] next_pc;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_err;
    logic        misalign_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .curr_pc_i     (curr_pc),
        .next_pc_o     (next_pc),
        .pc_en_o       (pc_en),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .instr_o       (instr),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .fetch_err_o   (fetch_err),
        .misalign_err_o(misalign_err)
    );

    typedef struct {
        logic [31:0] pc;
        logic        rv;
        logic [31:0] rd;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] e_npc;
        logic        e_pcen;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_instr;
        logic        e_err;
        logic        e_mis;
    } vec_t;

    vec_t tv[32];

    function automatic vec_t mk(
        input logic [31:0] pc, input logic rv, input logic [31:0] rd,
        input logic rdy, input logic redir, input logic [31:0] rpc,
        input logic [31:0] e_npc, input logic e_pcen, input logic e_req,
        input logic [31:0] e_addr, input logic e_val, input logic [31:0] e_instr,
        input logic e_err, input logic e_mis);
        vec_t v;
        v.pc = pc;       v.rv = rv;         v.rd = rd;
        v.rdy = rdy;     v.redir = redir;   v.rpc = rpc;
        v.e_npc = e_npc; v.e_pcen = e_pcen; v.e_req = e_req;
        v.e_addr = e_addr; v.e_val = e_val; v.e_instr = e_instr;
        v.e_err = e_err; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic rv, input logic [31:0] rd,
                         input logic rdy, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        curr_pc     = pc;
        imem_rvalid = rv;
        imem_rdata  = rd;
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n = 1'b0; curr_pc = '0; imem_rvalid = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Cycle trace: PC model values are hand-computed from previous pc_en/next_pc.
        tv[0]  = mk(32'h0, O, 32'h0, O, I, 32'h41,        32'h0, O, O, 32'h0, O, 32'h0, O, O);
        tv[1]  = mk(32'h0, I, 32'hA000_0000, I, O, 32'h0, 32'h0, O, I, 32'h0, O, 32'h0, O, O);
        tv[2]  = mk(32'h0, O, 32'h0, I, O, 32'h0,         32'h4, I, O, 32'h0, I, 32'hA000_0000, O, O);
        tv[3]  = mk(32'h4, I, 32'hA000_0001, I, O, 32'h0, 32'h0, O, I, 32'h4, O, 32'hA000_0000, O, O);
        tv[4]  = mk(32'h4, O, 32'h0, I, O, 32'h0,         32'h8, I, O, 32'h0, I, 32'hA000_0001, O, O);
        tv[5]  = mk(32'h8, I, 32'hA000_0002, I, O, 32'h0, 32'h0, O, I, 32'h8, O, 32'hA000_0001, O, O);
        tv[6]  = mk(32'h8, O, 32'h0, I, O, 32'h0,         32'hC, I, O, 32'h0, I, 32'hA000_0002, O, O);
        tv[7]  = mk(32'hC, O, 32'h0, I, O, 32'h0,         32'h0, O, I, 32'hC, O, 32'hA000_0002, O, O);
        tv[8]  = mk(32'hC, O, 32'h55, I, O, 32'h0,        32'h0, O, I, 32'hC, O, 32'hA000_0002, O, O);
        tv[9]  = mk(32'hC, I, 32'hA000_0003, I, O, 32'h0, 32'h0, O, I, 32'hC, O, 32'hA000_0002, O, O);
        for (int k = 10; k < 15; k++)
            tv[k] = mk(32'hC, O, 32'h0, O, O, 32'h0,      32'h0, O, O, 32'h0, I, 32'hA000_0003, O, O);
        tv[15] = mk(32'hC, O, 32'h0, I, O, 32'h0,         32'h10, I, O, 32'h0, I, 32'hA000_0003, O, O);
        tv[16] = mk(32'h10, O, 32'h0, I, I, 32'h100,      32'h100, I, I, 32'h10, O, 32'hA000_0003, O, O);
        tv[17] = mk(32'h100, O, 32'h0, I, O, 32'h0,       32'h0, O, O, 32'h0, O, 32'hA000_0003, O, O);
        tv[18] = mk(32'h100, I, 32'hDEAD, I, O, 32'h0,    32'h0, O, O, 32'h0, O, 32'hA000_0003, O, O);
        tv[19] = mk(32'h100, I, 32'hB000_0000, I, O, 32'h0, 32'h0, O, I, 32'h100, O, 32'hA000_0003, O, O);
        tv[20] = mk(32'h100, O, 32'h0, I, I, 32'h200,     32'h200, I, O, 32'h0, I, 32'hB000_0000, O, O);
        tv[21] = mk(32'h200, I, 32'hBAD, I, I, 32'h300,   32'h300, I, I, 32'h200, O, 32'hB000_0000, O, O);
        tv[22] = mk(32'h300, I, 32'hB000_0001, I, O, 32'h0, 32'h0, O, I, 32'h300, O, 32'hB000_0000, O, O);
        tv[23] = mk(32'h300, O, 32'h0, I, O, 32'h0,       32'h304, I, O, 32'h0, I, 32'hB000_0001, O, O);
        tv[24] = mk(32'h304, O, 32'h0, I, I, 32'hFFFF_FFFC, 32'hFFFF_FFFC, I, I, 32'h304, O, 32'hB000_0001, O, O);
        tv[25] = mk(32'hFFFF_FFFC, I, 32'hDEAD, I, I, 32'hFFFF_FFFC, 32'hFFFF_FFFC, I, O, 32'h0, O, 32'hB000_0001, O, O);
        tv[26] = mk(32'hFFFF_FFFC, I, 32'hB000_0002, I, O, 32'h0, 32'h0, O, I, 32'hFFFF_FFFC, O, 32'hB000_0001, O, O);
        tv[27] = mk(32'hFFFF_FFFC, O, 32'h0, I, O, 32'h0, 32'h0, I, O, 32'h0, I, 32'hB000_0002, O, O);
        tv[28] = mk(32'h0, O, 32'h0, I, I, 32'h102,       NP, I, I, 32'h0, O, 32'hB000_0002, O, O);
        tv[29] = mk(NP, I, 32'hDEAD, I, O, 32'h0,         32'h0, O, O, 32'h0, O, 32'hB000_0002, O, ALN);
        tv[30] = mk(NP, I, 32'hB000_0003, I, O, 32'h0,    32'h0, O, I, NP, O, 32'hB000_0002, O, ALN);
        tv[31] = mk(NP, O, 32'h0, I, O, 32'h0,            NP + 32'd4, I, O, 32'h0, I, 32'hB000_0003, O, ALN);

        #3;
        chk("rst.req",   32'(imem_req), 32'h0);
        chk("rst.pcen",  32'(pc_en), 32'h0);
        chk("rst.valid", 32'(instr_valid), 32'h0);
        chk("rst.instr", instr, 32'h0);
        chk("rst.err",   32'(fetch_err), 32'h0);
        chk("rst.mis",   32'(misalign_err), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            drive(tv[i].pc, tv[i].rv, tv[i].rd, tv[i].rdy, tv[i].redir, tv[i].rpc);
            chk($sformatf("r%0d.next_pc", i),  next_pc, tv[i].e_npc);
            chk($sformatf("r%0d.pc_en", i),    32'(pc_en), 32'(tv[i].e_pcen));
            chk($sformatf("r%0d.imem_req", i), 32'(imem_req), 32'(tv[i].e_req));
            chk($sformatf("r%0d.imem_addr", i), imem_addr, tv[i].e_addr);
            chk($sformatf("r%0d.instr_valid", i), 32'(instr_valid), 32'(tv[i].e_val));
            chk($sformatf("r%0d.instr", i),    instr, tv[i].e_instr);
            chk($sformatf("r%0d.fetch_err", i), 32'(fetch_err), 32'(tv[i].e_err));
            chk($sformatf("r%0d.misalign", i), 32'(misalign_err), 32'(tv[i].e_mis));
        end

        // Watchdog: four FETCH cycles with no response, then sticky error.
        for (int k = 0; k < 4; k++) begin
            drive(NP + 32'd4, O, 32'h0, O, O, 32'h0);
            chk($sformatf("wd%0d.err_low", k), 32'(fetch_err), 32'h0);
            chk($sformatf("wd%0d.req", k), 32'(imem_req), 32'h1);
        end
        for (int k = 0; k < 3; k++) begin
            drive(NP + 32'd4, O, 32'h0, O, O, 32'h0);
            chk($sformatf("wd_sat%0d.err", k), 32'(fetch_err), 32'h1);
            chk($sformatf("wd_sat%0d.addr", k), imem_addr, NP + 32'd4);
        end
        drive(NP + 32'd4, I, 32'hC000_0000, O, O, 32'h0);
        chk("wd_rv.err", 32'(fetch_err), 32'h1);
        drive(NP + 32'd4, O, 32'h0, I, O, 32'h0);
        chk("wd_hold.valid", 32'(instr_valid), 32'h1);
        chk("wd_hold.instr", instr, 32'hC000_0000);
        chk("wd_hold.next_pc", next_pc, NP + 32'd8);
        chk("wd_hold.err", 32'(fetch_err), 32'h1);
        drive(NP + 32'd8, O, 32'h0, I, O, 32'h0);
        chk("wd_fetch.err", 32'(fetch_err), 32'h1);

        // Asynchronous reset mid-cycle, with a stale response still arriving.
        rst_n = 1'b0;
        #1;
        chk("arst.err",   32'(fetch_err), 32'h0);
        chk("arst.req",   32'(imem_req), 32'h0);
        chk("arst.instr", instr, 32'h0);
        chk("arst.mis",   32'(misalign_err), 32'h0);
        drive(32'h0, I, 32'hDEAD, I, O, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(32'h0, I, 32'hDEAD, I, O, 32'h0);
        chk("post_rst.idle_req", 32'(imem_req), 32'h0);
        chk("post_rst.idle_pcen", 32'(pc_en), 32'h0);
        chk("post_rst.instr", instr, 32'h0);
        drive(32'h0, O, 32'h0, I, O, 32'h0);
        chk("post_rst.fetch_req", 32'(imem_req), 32'h1);
        chk("post_rst.fetch_addr", imem_addr, 32'h0);
        chk("post_rst.valid", 32'(instr_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
